// File: rtl/priority_encoder_83_reg_if.sv
// Request-vector / encoded-index bundle for the registered priority encoder.
//   data_in : request vector, driven by the requester (master)
//   out     : registered index of the highest set request bit, driven by the encoder (slave)
//   valid   : registered, 1 when any request bit was set, driven by the encoder (slave)
interface priority_encoder_83_reg_if #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 3
);

  logic [IN_WIDTH-1:0]  data_in;
  logic [OUT_WIDTH-1:0] out;
  logic                 valid;

  modport master (
    output data_in,
    input  out,
    input  valid
  );

  modport slave (
    input  data_in,
    output out,
    output valid
  );

endinterface

// File: rtl/priority_encoder_83_reg.sv
// Registered MSB-first priority encoder.
// Each rising edge captures the index of the highest set bit of data_in on
// out, and the OR of data_in on valid. Latency is one cycle, with one new
// input accepted every cycle. Downstream logic must qualify out with valid.
//   clk : rising-edge clock
//   rst : synchronous active-high reset; clears out and valid
//   bus : data_in in; out and valid registered out
module priority_encoder_83_reg #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  priority_encoder_83_reg_if.slave      bus
);

  logic [OUT_WIDTH-1:0] out_d, out_q;
  logic                 valid_d, valid_q;

  // Scan from LSB to MSB. The last set bit seen wins, so higher bits take priority.
  always_comb begin
    out_d   = '0;
    valid_d = |bus.data_in;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (bus.data_in[i]) begin
        out_d = OUT_WIDTH'(i);
      end
    end
  end

  // Output register. Reset takes precedence over data_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_priority_encoder_83_reg.sv
// Self-checking bench for priority_encoder_83_reg, using a randomized stimulus
// and a behavioural reference model.
module tb_priority_encoder_83_reg;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 3;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;

  priority_encoder_83_reg_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

  priority_encoder_83_reg #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: floor(log2(x)) by repeated halving. Zero maps to 0.
  function automatic logic [OUT_W-1:0] ref_idx(input int unsigned x);
    int unsigned n;
    n = 0;
    while (x > 1) begin
      x = x / 2;
      n++;
    end
    return OUT_W'(n);
  endfunction

  function automatic logic ref_valid(input int unsigned x);
    return x != 0;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.data_in = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (bus.out !== 3'd0 || bus.valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: out=%0d valid=%b expected out=0 valid=0", c, bus.out, bus.valid);
      end
    end
    rst = 1'b0;
    bus.data_in = 8'h01;
    tick();
    checks++;
    if (bus.out !== 3'd0 || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: out=%0d valid=%b expected out=0 valid=1", bus.out, bus.valid);
    end
  endtask

  task automatic test_onehot();
    logic [IN_W-1:0] v;
    for (int i = 0; i < int'(IN_W); i++) begin
      v = '0;
      v[i] = 1'b1;
      bus.data_in = v;
      tick();
      checks++;
      if (bus.out !== OUT_W'(i) || bus.valid !== 1'b1) begin
        errors++;
        $display("FAIL onehot bit%0d: out=%0d valid=%b expected out=%0d valid=1", i, bus.out, bus.valid, i);
      end
    end
  endtask

  task automatic test_multibit();
    logic [IN_W-1:0]  vin [5] = '{8'b00000110, 8'b00010100, 8'b10000001, 8'b01111111, 8'b11111111};
    logic [OUT_W-1:0] vexp[5] = '{3'b010, 3'b100, 3'b111, 3'b110, 3'b111};
    for (int k = 0; k < 5; k++) begin
      bus.data_in = vin[k];
      tick();
      checks++;
      if (bus.out !== vexp[k] || bus.valid !== 1'b1) begin
        errors++;
        $display("FAIL multibit %b: out=%b valid=%b expected out=%b valid=1", vin[k], bus.out, bus.valid, vexp[k]);
      end
    end
  endtask

  task automatic test_zero();
    bus.data_in = 8'h00;
    tick();
    checks++;
    if (bus.out !== 3'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL zero: out=%0d valid=%b expected out=0 valid=0", bus.out, bus.valid);
    end
    bus.data_in = 8'b00001000;
    tick();
    checks++;
    if (bus.out !== 3'd3 || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_then_bit3: out=%0d valid=%b expected out=3 valid=1", bus.out, bus.valid);
    end
  endtask

  // Random back-to-back inputs, each preceded by a glitch value between edges.
  // Then a one-cycle reset while data_in = 0x20.
  task automatic test_latency_reset();
    logic [IN_W-1:0]  v;
    logic [OUT_W-1:0] eo;
    logic             ev;
    for (int c = 0; c < 40; c++) begin
      v = IN_W'($urandom);
      bus.data_in = IN_W'($urandom);
      #2;
      bus.data_in = v;
      tick();
      eo = ref_idx(int'(v));
      ev = ref_valid(int'(v));
      checks++;
      if (bus.out !== eo || bus.valid !== ev) begin
        errors++;
        $display("FAIL latency in=%h: out=%0d valid=%b expected out=%0d valid=%b", v, bus.out, bus.valid, eo, ev);
      end
      bus.data_in = IN_W'($urandom);
      #3;
      checks++;
      if (bus.out !== eo || bus.valid !== ev) begin
        errors++;
        $display("FAIL hold in=%h: out=%0d valid=%b expected out=%0d valid=%b", v, bus.out, bus.valid, eo, ev);
      end
    end
    bus.data_in = 8'b00100000;
    rst = 1'b1;
    tick();
    checks++;
    if (bus.out !== 3'd0 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset: out=%0d valid=%b expected out=0 valid=0", bus.out, bus.valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.out !== 3'd5 || bus.valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: out=%0d valid=%b expected out=5 valid=1", bus.out, bus.valid);
    end
  endtask

  task automatic test_exhaustive();
    logic [OUT_W-1:0] eo;
    logic             ev;
    for (int x = 0; x < 256; x++) begin
      bus.data_in = IN_W'(x);
      tick();
      eo = ref_idx(x);
      ev = ref_valid(x);
      checks++;
      if (bus.out !== eo || bus.valid !== ev) begin
        errors++;
        $display("FAIL exhaustive in=%h: out=%0d valid=%b expected out=%0d valid=%b", x, bus.out, bus.valid, eo, ev);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.data_in = '0;
    test_reset();
    test_onehot();
    test_multibit();
    test_zero();
    test_latency_reset();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
